// File: rtl/seg7_scan_driver_if.sv
// Bundle for the multiplexed 7-segment driver: load side (value, dp_in, blank_lz, load)
// and pin side (seg, dp, an, frame_done).
// master = status/counter source that feeds values in; slave = the scan driver itself.
// No handshake: load is a one-cycle strobe that the driver always accepts.
interface seg7_scan_driver_if #(
  parameter int DIGITS = 4
) ();
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp_in;
  logic                  blank_lz;
  logic [6:0]            seg;
  logic                  dp;
  logic [DIGITS-1:0]     an;
  logic                  frame_done;

  modport master (
    output load, value, dp_in, blank_lz,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  load, value, dp_in, blank_lz,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed DIGITS-wide hex display driver with prescaled scan, double-buffered load,
// leading-zero blanking, polarity control and a frame-done strobe.
// Latency: seg/dp/an registered, one cycle after the scan index moves; no backpressure (load always taken).
// Ports: clk, rst_n (async active-low); bus.slave carries load/value/dp_in/blank_lz in and
// seg/dp/an/frame_done out.
module seg7_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int CLK_DIV        = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit AN_ACTIVE_LOW  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  seg7_scan_driver_if.slave bus
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0]     PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0]     IDX_MAX   = IW'(DIGITS - 1);
  // XOR masks that turn "lit/enabled = 1" into the pin level.
  localparam logic [6:0]        SEG_INV   = {7{SEG_ACTIVE_LOW}};
  localparam logic              DP_INV    = SEG_ACTIVE_LOW;
  localparam logic [DIGITS-1:0] AN_INV    = {DIGITS{AN_ACTIVE_LOW}};

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  logic [PW-1:0]          presc_q, presc_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [4*DIGITS-1:0]    pend_val_q, pend_val_d;
  logic [DIGITS-1:0]      pend_dp_q, pend_dp_d;
  logic                   pend_flag_q, pend_flag_d;
  logic [4*DIGITS-1:0]    disp_val_q, disp_val_d;
  logic [DIGITS-1:0]      disp_dp_q, disp_dp_d;
  logic                   frame_done_q, frame_done_d;
  logic [6:0]             seg_q, seg_d;
  logic                   dp_q, dp_d;
  logic [DIGITS-1:0]      an_q, an_d;

  logic                   tick;
  logic                   boundary;
  logic                   upper_zero;
  logic [DIGITS-1:0]      lz_dark;
  logic [3:0]             cur_nib;
  logic [6:0]             seg_lit;
  logic [DIGITS-1:0]      an_onehot;

  always_comb begin
    presc_d      = presc_q;
    idx_d        = idx_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_flag_d  = pend_flag_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    upper_zero   = 1'b1;
    lz_dark      = '0;
    an_onehot    = '0;

    // Prescaler and scan index.
    tick     = (presc_q == PRESC_MAX);
    boundary = tick && (idx_q == IDX_MAX);
    if (tick) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
    end else begin
      presc_d = presc_q + PW'(1);
    end

    // Double buffer: display only ever changes on the frame boundary, so a
    // scan never shows a mix of old and new digits.
    if (boundary) begin
      if (bus.load) begin
        disp_val_d = bus.value;
        disp_dp_d  = bus.dp_in;
      end else if (pend_flag_q) begin
        disp_val_d = pend_val_q;
        disp_dp_d  = pend_dp_q;
      end
      pend_flag_d = 1'b0;
    end else if (bus.load) begin
      pend_val_d  = bus.value;
      pend_dp_d   = bus.dp_in;
      pend_flag_d = 1'b1;
    end

    frame_done_d = boundary;

    // Digit i is a leading zero when it and every higher nibble are zero.
    // Digit 0 is excluded so a value of zero still shows "0".
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero && (disp_val_q[4*i +: 4] == 4'h0);
      lz_dark[i] = upper_zero;
    end

    cur_nib = disp_val_q[{idx_q, 2'b00} +: 4];
    seg_lit = hex_to_seg(cur_nib);
    if (bus.blank_lz && lz_dark[idx_q]) begin
      seg_lit = 7'b0000000;
    end

    for (int i = 0; i < DIGITS; i++) begin
      an_onehot[i] = (idx_q == IW'(i));
    end

    seg_d = seg_lit ^ SEG_INV;
    dp_d  = disp_dp_q[idx_q] ^ DP_INV;
    an_d  = an_onehot ^ AN_INV;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_flag_q  <= 1'b0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      frame_done_q <= 1'b0;
      seg_q        <= SEG_INV;
      dp_q         <= DP_INV;
      an_q         <= AN_INV;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_flag_q  <= pend_flag_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      frame_done_q <= frame_done_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  logic clk;
  logic rst_n;
  logic rst2_n;

  seg7_scan_driver_if #(.DIGITS(4)) bus ();
  seg7_scan_driver_if #(.DIGITS(4)) bus2 ();

  seg7_scan_driver #(
    .DIGITS(4), .CLK_DIV(4), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  seg7_scan_driver #(
    .DIGITS(4), .CLK_DIV(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut_low (
    .clk(clk), .rst_n(rst2_n), .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned ncyc;
    logic        ld;
    logic [15:0] val;
    logic [3:0]  dpi;
    logic        blz;
    logic [6:0]  eseg;
    logic        edp;
    logic [3:0]  ean;
    logic        efd;
    string       name;
  } row_t;

  row_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic add(input int unsigned n, input logic ld, input logic [15:0] v,
                     input logic [3:0] d, input logic b, input logic [6:0] s,
                     input logic p, input logic [3:0] a, input logic f, input string nm);
    row_t r;
    r.ncyc = n; r.ld = ld; r.val = v; r.dpi = d; r.blz = b;
    r.eseg = s; r.edp = p; r.ean = a; r.efd = f; r.name = nm;
    tbl.push_back(r);
  endtask

  task automatic chk_main(input string nm, input logic [6:0] s, input logic p,
                          input logic [3:0] a, input logic f);
    chk({nm, ".seg"}, 32'(bus.seg), 32'(s));
    chk({nm, ".dp"},  32'(bus.dp),  32'(p));
    chk({nm, ".an"},  32'(bus.an),  32'(a));
    chk({nm, ".fd"},  32'(bus.frame_done), 32'(f));
  endtask

  task automatic chk_low(input string nm, input logic [6:0] s, input logic p,
                         input logic [3:0] a, input logic f);
    chk({nm, ".seg"}, 32'(bus2.seg), 32'(s));
    chk({nm, ".dp"},  32'(bus2.dp),  32'(p));
    chk({nm, ".an"},  32'(bus2.an),  32'(a));
    chk({nm, ".fd"},  32'(bus2.frame_done), 32'(f));
  endtask

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.load  = 1'b0;
      bus2.load = 1'b0;
    end
  endtask

  initial begin
    // Comment column: edge count after reset release at which outputs are checked.
    // 1: idle scan, value 0
    add(1,  0, 16'h0000, 4'b0000, 0, 7'b1111110, 0, 4'b0001, 0, "s1_c1");
    add(3,  0, 16'h0000, 4'b0000, 0, 7'b1111110, 0, 4'b0001, 0, "s1_c4");
    add(1,  0, 16'h0000, 4'b0000, 0, 7'b1111110, 0, 4'b0010, 0, "s1_c5");
    add(4,  0, 16'h0000, 4'b0000, 0, 7'b1111110, 0, 4'b0100, 0, "s1_c9");
    add(4,  0, 16'h0000, 4'b0000, 0, 7'b1111110, 0, 4'b1000, 0, "s1_c13");
    add(2,  0, 16'h0000, 4'b0000, 0, 7'b1111110, 0, 4'b1000, 0, "s1_c15");
    add(1,  0, 16'h0000, 4'b0000, 0, 7'b1111110, 0, 4'b1000, 1, "s1_c16");
    add(1,  0, 16'h0000, 4'b0000, 0, 7'b1111110, 0, 4'b0001, 0, "s1_c17");
    // 2: load 12AF at start of frame, visible only from the next frame
    add(1,  1, 16'h12AF, 4'b0100, 0, 7'b1111110, 0, 4'b0001, 0, "s2_c18");
    add(6,  0, 16'h12AF, 4'b0100, 0, 7'b1111110, 0, 4'b0010, 0, "s2_c24");
    add(7,  0, 16'h12AF, 4'b0100, 0, 7'b1111110, 0, 4'b1000, 0, "s2_c31");
    add(1,  0, 16'h12AF, 4'b0100, 0, 7'b1111110, 0, 4'b1000, 1, "s2_c32");
    add(1,  0, 16'h12AF, 4'b0100, 0, 7'b1000111, 0, 4'b0001, 0, "s2_c33");
    add(4,  0, 16'h12AF, 4'b0100, 0, 7'b1110111, 0, 4'b0010, 0, "s2_c37");
    add(4,  0, 16'h12AF, 4'b0100, 0, 7'b1101101, 1, 4'b0100, 0, "s2_c41");
    add(4,  0, 16'h12AF, 4'b0100, 0, 7'b0110000, 0, 4'b1000, 0, "s2_c45");
    // 3: 0050 with leading-zero blanking, then blanking off
    add(3,  1, 16'h0050, 4'b0000, 1, 7'b0110000, 0, 4'b1000, 1, "s3_c48");
    add(1,  0, 16'h0050, 4'b0000, 1, 7'b1111110, 0, 4'b0001, 0, "s3_c49");
    add(4,  0, 16'h0050, 4'b0000, 1, 7'b1011011, 0, 4'b0010, 0, "s3_c53");
    add(4,  0, 16'h0050, 4'b0000, 1, 7'b0000000, 0, 4'b0100, 0, "s3_c57");
    add(4,  0, 16'h0050, 4'b0000, 1, 7'b0000000, 0, 4'b1000, 0, "s3_c61");
    add(4,  0, 16'h0050, 4'b0000, 0, 7'b1111110, 0, 4'b0001, 0, "s3_c65");
    add(8,  0, 16'h0050, 4'b0000, 0, 7'b1111110, 0, 4'b0100, 0, "s3_c73");
    add(4,  0, 16'h0050, 4'b0000, 0, 7'b1111110, 0, 4'b1000, 0, "s3_c77");
    // 4: overwrite of pending, then load on the boundary cycle itself
    add(7,  0, 16'h0050, 4'b0000, 0, 7'b1111110, 0, 4'b0001, 0, "s4_c84");
    add(1,  1, 16'h1111, 4'b0000, 0, 7'b1011011, 0, 4'b0010, 0, "s4_c85");
    add(1,  0, 16'h1111, 4'b0000, 0, 7'b1011011, 0, 4'b0010, 0, "s4_c86");
    add(1,  1, 16'h2222, 4'b0000, 0, 7'b1011011, 0, 4'b0010, 0, "s4_c87");
    add(9,  0, 16'h2222, 4'b0000, 0, 7'b1111110, 0, 4'b1000, 1, "s4_c96");
    add(1,  0, 16'h2222, 4'b0000, 0, 7'b1101101, 0, 4'b0001, 0, "s4_c97");
    add(4,  0, 16'h2222, 4'b0000, 0, 7'b1101101, 0, 4'b0010, 0, "s4_c101");
    add(10, 0, 16'h2222, 4'b0000, 0, 7'b1101101, 0, 4'b1000, 0, "s4_c111");
    add(1,  1, 16'h3333, 4'b0000, 0, 7'b1101101, 0, 4'b1000, 1, "s4_c112");
    add(1,  0, 16'h3333, 4'b0000, 0, 7'b1111001, 0, 4'b0001, 0, "s4_c113");
    add(12, 0, 16'h3333, 4'b0000, 0, 7'b1111001, 0, 4'b1000, 0, "s4_c125");
    add(4,  0, 16'h3333, 4'b0000, 0, 7'b1111001, 0, 4'b0001, 0, "s4_c129");

    rst_n = 1'b0;
    rst2_n = 1'b0;
    bus.load = 1'b0;  bus.value = '0;  bus.dp_in = '0;  bus.blank_lz = 1'b0;
    bus2.load = 1'b0; bus2.value = '0; bus2.dp_in = '0; bus2.blank_lz = 1'b0;

    #12;
    chk_main("rst_main", 7'b0000000, 0, 4'b0000, 0);
    chk_low("rst_low", 7'b1111111, 1, 4'b1111, 0);

    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[r]) begin
      bus.value    = tbl[r].val;
      bus.dp_in    = tbl[r].dpi;
      bus.blank_lz = tbl[r].blz;
      bus.load     = tbl[r].ld;
      step(tbl[r].ncyc);
      chk_main(tbl[r].name, tbl[r].eseg, tbl[r].edp, tbl[r].ean, tbl[r].efd);
    end

    // 5: reset mid-frame with a load pending; the load must be lost.
    bus.value = 16'h4444;
    bus.load  = 1'b1;
    step(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_main("s5_async", 7'b0000000, 0, 4'b0000, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    chk_main("s5_c1", 7'b1111110, 0, 4'b0001, 0);
    step(15);
    chk_main("s5_c16", 7'b1111110, 0, 4'b1000, 1);
    step(1);
    chk_main("s5_c17", 7'b1111110, 0, 4'b0001, 0);

    // 6: active-low pins on the second instance.
    @(negedge clk);
    chk_low("s6_rst", 7'b1111111, 1, 4'b1111, 0);
    rst2_n = 1'b1;
    bus2.value = 16'h0008;
    bus2.load  = 1'b1;
    step(1);
    chk_low("s6_c1", 7'b0000001, 1, 4'b1110, 0);
    step(4);
    chk_low("s6_c5", 7'b0000001, 1, 4'b1101, 0);
    step(11);
    chk_low("s6_c16", 7'b0000001, 1, 4'b0111, 1);
    step(1);
    chk_low("s6_c17", 7'b0000000, 1, 4'b1110, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
